vga_mem_arbiter: RTL and testbench
==================================

# vga_mem_arbiter

Two-requester arbiter for the single memory port shared by the VGA address generator (frame-buffer glyph fetches) and the CPU load/store path. Each requester presents a held request with a one-cycle acknowledge. The arbiter registers the winning address, write data and write enable onto the memory port, and returns read data with a valid pulse a fixed two cycles after acknowledge. The VGA requester has priority; an optional starvation guard bounds CPU wait time.

## Interface
Parameters:
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 16, memory word width.
- STARVE_LIMIT, 8, guard threshold in cycles; used only with the guard compiled in; legal range 1-255.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- vga_req  in  1  VGA read request; held with vga_addr until acknowledged.
- vga_addr  in  ADDR_WIDTH  VGA read address.
- vga_ack  out  1  one-cycle pulse; VGA request accepted.
- vga_rdata  out  DATA_WIDTH  VGA read data; holds its value between updates.
- vga_valid  out  1  one-cycle pulse; vga_rdata updated.
- cpu_req  in  1  CPU request; held with cpu_we, cpu_addr and cpu_wdata until acknowledged.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_ack  out  1  one-cycle pulse; CPU request accepted.
- cpu_rdata  out  DATA_WIDTH  CPU read data; holds its value between updates.
- cpu_valid  out  1  one-cycle pulse, reads only.
- mem_addr  out  ADDR_WIDTH  registered memory address.
- mem_wdata  out  DATA_WIDTH  registered memory write data.
- mem_we  out  1  registered write enable; a one-cycle pulse per write.
- mem_rdata  in  DATA_WIDTH  synchronous memory read data, valid one cycle after mem_addr is presented.

## Operation
- **Eligibility.** A requester is eligible in a cycle when its req is high and its own ack is low. This masks the cycle in which the requester is still reacting to ack, so each requester is granted at most once every two cycles.
- **Arbitration.** Evaluated every cycle.
  - VGA eligible: VGA wins.
  - Otherwise, CPU eligible: CPU wins.
  - Otherwise: idle cycle.
- **On a grant at edge E:**
  - mem_addr takes the winner's address.
  - mem_wdata takes cpu_wdata on a CPU write; otherwise it holds.
  - mem_we is 1 only for a CPU write.
  - The winner's ack goes high for exactly one cycle.
- **Idle cycle.** mem_we = 0; mem_addr and mem_wdata hold their values.
- **Read tracking.** A 2-stage tag pipeline tracks reads. Each tag is {valid, owner}; writes insert no tag.
  - Stage 2 captures mem_rdata into the owner's rdata register.
  - Stage 2 pulses the owner's valid.
- **Arithmetic.** No arithmetic on addresses or data; pass-through only.
- **Boundary conditions.**
  - Both requesters eligible: VGA wins. CPU stays pending with req held, and is re-evaluated the next cycle.
  - Back-to-back grants alternate owners when both request continuously: VGA, CPU, VGA, ...
  - req dropped before ack: the request is withdrawn with no side effects.
  - Reset mid-operation: in-flight tags are cleared; no valid is produced for reads acknowledged before reset.

## Timing
- **Reset values.** All outputs are 0: acks, valids, mem_we, mem_addr, mem_wdata, vga_rdata, cpu_rdata. The tag pipeline is empty and the guard counter is 0.
- **Request to ack.** A request sampled at edge E0 raises ack after E0.
- **Memory port.** mem_* are driven after E0. Memory samples them at E1.
- **Read data.** Captured at E2; valid is high during the cycle after E2.
- **Latency.** Read valid follows ack by 2 cycles.
- **Writes.** mem_we is high during the single cycle after E0.
- **Throughput.** One memory access per cycle overall; one per two cycles per requester.

## Configuration
- **Macro: VGA_ARB_STARVE_GUARD_EN.**
- **Defined:**
  - An 8-bit counter increments each cycle the CPU is eligible and not granted, saturating at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT, the CPU wins the next arbitration even if VGA is eligible.
  - The counter clears on any CPU grant.
- **Undefined:** Strict VGA priority. No counter logic is synthesized, and STARVE_LIMIT is ignored.

## Test plan
- **Reset mid-read.** Assert reset at any time, including one cycle after a vga_ack. Required: every output reads 0; no vga_valid follows release.
- **VGA read.** vga_req held with vga_addr=0x3005, memory word 0x4142. Required: vga_ack 1 cycle after sampling; mem_addr=0x3005; vga_valid 2 cycles after vga_ack with vga_rdata=0x4142.
- **CPU write.** cpu_req with cpu_we=1, cpu_addr=0x0010, cpu_wdata=0xBEEF. Required: cpu_ack; mem_we high for exactly 1 cycle with mem_addr=0x0010 and mem_wdata=0xBEEF; no cpu_valid.
- **Contention.** vga_req and cpu_req (read 0x0020) rise in the same cycle. Required: vga_ack first, cpu_ack the next cycle, and both valids in the same order 2 cycles later.
- **Continuous VGA, guard undefined.** vga_req held high (re-issued each grant) for 20 cycles with cpu_req pending. Required: grants alternate VGA and CPU, because ack masking leaves the CPU eligible on every other cycle.
- **Guard defined.** VGA_ARB_STARVE_GUARD_EN with STARVE_LIMIT=1; the VGA model keeps vga_req eligible every cycle. Required: cpu_ack within 2 cycles of cpu_req.

Source files
------------

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one synchronous memory port between the VGA glyph
// fetcher (priority requester, reads only) and the CPU load/store path.
// Read data returns to its owner two cycles after the acknowledge.
// Optional CPU starvation guard: define VGA_ARB_STARVE_GUARD_EN.
module vga_mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic                  vga_ack,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  output logic                  vga_valid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Tag owner encoding for the read-return pipeline.
  localparam logic OWN_VGA = 1'b0;
  localparam logic OWN_CPU = 1'b1;

  // The guard counter is 8 bits wide, so the threshold must fit in it.
  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_limit_check
    $error("STARVE_LIMIT must be in the range 1..255");
  end

  logic                  vga_ack_q, cpu_ack_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  tag1_v_q, tag1_own_q;
  logic                  tag2_v_q, tag2_own_q;
  logic [DATA_WIDTH-1:0] vga_rdata_q, cpu_rdata_q;
  logic                  vga_valid_q, cpu_valid_q;

  logic vga_elig, cpu_elig, grant_vga, grant_cpu, rd_grant, force_cpu;

  // A requester still seeing its own ack is masked, so a held req is not
  // granted twice for the same transaction.
  assign vga_elig = vga_req & ~vga_ack_q;
  assign cpu_elig = cpu_req & ~cpu_ack_q;

`ifdef VGA_ARB_STARVE_GUARD_EN
  logic [7:0] starve_q, starve_d;

  assign force_cpu = (starve_q == 8'(STARVE_LIMIT));

  // Count cycles the CPU waits while eligible; saturate at the threshold.
  always_comb begin
    starve_d = starve_q;
    if (grant_cpu) begin
      starve_d = '0;
    end else if (cpu_elig && (starve_q != 8'(STARVE_LIMIT))) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign force_cpu = 1'b0;
`endif

  // Priority arbitration and next memory-port values; idle cycles hold addr/data.
  always_comb begin
    grant_cpu   = cpu_elig & (~vga_elig | force_cpu);
    grant_vga   = vga_elig & ~grant_cpu;
    rd_grant    = grant_vga | (grant_cpu & ~cpu_we);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = grant_cpu & cpu_we;
    if (grant_vga) begin
      mem_addr_d = vga_addr;
    end else if (grant_cpu) begin
      mem_addr_d = cpu_addr;
      if (cpu_we) mem_wdata_d = cpu_wdata;
    end
  end

  // Memory port and acknowledge registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      vga_ack_q   <= grant_vga;
      cpu_ack_q   <= grant_cpu;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  // Two-stage read tag pipeline; stage 2 lines up with mem_rdata and routes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag1_v_q    <= 1'b0;
      tag1_own_q  <= OWN_VGA;
      tag2_v_q    <= 1'b0;
      tag2_own_q  <= OWN_VGA;
      vga_valid_q <= 1'b0;
      cpu_valid_q <= 1'b0;
      vga_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      tag1_v_q    <= rd_grant;
      tag1_own_q  <= grant_cpu ? OWN_CPU : OWN_VGA;
      tag2_v_q    <= tag1_v_q;
      tag2_own_q  <= tag1_own_q;
      vga_valid_q <= tag2_v_q & (tag2_own_q == OWN_VGA);
      cpu_valid_q <= tag2_v_q & (tag2_own_q == OWN_CPU);
      if (tag2_v_q && (tag2_own_q == OWN_VGA)) vga_rdata_q <= mem_rdata;
      if (tag2_v_q && (tag2_own_q == OWN_CPU)) cpu_rdata_q <= mem_rdata;
    end
  end

  assign vga_ack   = vga_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign vga_rdata = vga_rdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vga_valid = vga_valid_q;
  assign cpu_valid = cpu_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Testbench for vga_mem_arbiter: directed steps, a synchronous memory model,
// and per-owner scoreboards of expected read data and arrival cycle.
module tb_vga_mem_arbiter;

  logic        clk, reset;
  logic        vga_req, vga_ack, vga_valid;
  logic [15:0] vga_addr, vga_rdata;
  logic        cpu_req, cpu_we, cpu_ack, cpu_valid;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  exp_t vga_exp[$];
  exp_t cpu_exp[$];
  exp_t e;
  int   grant_log[$];
  bit   log_en = 1'b0;

  logic [15:0] mem [0:255];

  vga_mem_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .STARVE_LIMIT(1)
  ) dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
    .vga_rdata(vga_rdata), .vga_valid(vga_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_valid(cpu_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: read data valid one cycle after the address.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vga_ack"},   vga_ack,   0);
    chk({tag, "_cpu_ack"},   cpu_ack,   0);
    chk({tag, "_vga_valid"}, vga_valid, 0);
    chk({tag, "_cpu_valid"}, cpu_valid, 0);
    chk({tag, "_mem_we"},    mem_we,    0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_vga_rdata"}, vga_rdata, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
  endtask

  task automatic wait_ack(input bit is_cpu, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_cpu ? cpu_ack : vga_ack) && n < 8);
    chk(tag, is_cpu ? cpu_ack : vga_ack, 1);
  endtask

  // Scoreboard: push expected read data on each read ack, pop on each valid.
  always @(negedge clk) begin
    if (vga_ack) begin
      vga_exp.push_back('{cyc + 2, mem[vga_addr[7:0]]});
      if (log_en) grant_log.push_back(0);
    end
    if (cpu_ack) begin
      if (!cpu_we) cpu_exp.push_back('{cyc + 2, mem[cpu_addr[7:0]]});
      else $display("[TB] cpu write addr=%h data=%h", cpu_addr, cpu_wdata);
      if (log_en) grant_log.push_back(1);
    end
    if (vga_valid) begin
      if (vga_exp.size() == 0) begin
        chk("vga_valid_unexpected", 1, 0);
      end else begin
        e = vga_exp.pop_front();
        chk("sb_vga_cycle", cyc, e.due);
        chk("sb_vga_rdata", vga_rdata, e.data);
        $display("[TB] vga read data=%h expected=%h", vga_rdata, e.data);
      end
    end
    if (cpu_valid) begin
      if (cpu_exp.size() == 0) begin
        chk("cpu_valid_unexpected", 1, 0);
      end else begin
        e = cpu_exp.pop_front();
        chk("sb_cpu_cycle", cyc, e.due);
        chk("sb_cpu_rdata", cpu_rdata, e.data);
        $display("[TB] cpu read data=%h expected=%h", cpu_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    vga_req = 0; vga_addr = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    for (int i = 0; i < 256; i++) mem[i] <= 16'(i) ^ 16'h5A5A;
    mem[8'h05] <= 16'h4142;
    mem[8'h20] <= 16'h1234;

    // Reset values
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // VGA read
    @(posedge clk); #1 vga_req = 1; vga_addr = 16'h3005;
    @(negedge clk); chk("vga_ack_early", vga_ack, 0);
    @(negedge clk);
    chk("vga_ack", vga_ack, 1);
    chk("vga_mem_addr", mem_addr, 16'h3005);
    chk("vga_mem_we", mem_we, 0);
    @(posedge clk); #1 vga_req = 0;
    @(negedge clk);
    chk("vga_ack_pulse", vga_ack, 0);
    chk("vga_valid_early", vga_valid, 0);
    @(negedge clk);
    chk("vga_valid", vga_valid, 1);
    chk("vga_rdata", vga_rdata, 16'h4142);
    @(negedge clk);
    chk("vga_valid_pulse", vga_valid, 0);
    chk("vga_rdata_hold", vga_rdata, 16'h4142);

    // CPU write
    @(posedge clk); #1 cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    wait_ack(1, "cpu_wr_ack");
    chk("cpu_wr_mem_we", mem_we, 1);
    chk("cpu_wr_mem_addr", mem_addr, 16'h0010);
    chk("cpu_wr_mem_wdata", mem_wdata, 16'hBEEF);
    @(posedge clk); #1 cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    chk("cpu_wr_we_pulse", mem_we, 0);
    chk("cpu_wr_ack_pulse", cpu_ack, 0);
    chk("cpu_wr_wdata_hold", mem_wdata, 16'hBEEF);
    repeat (2) begin
      @(negedge clk); chk("cpu_wr_no_valid", cpu_valid, 0);
    end

    // Contention: VGA first, CPU next cycle, valids in the same order
    @(posedge clk); #1
    vga_req = 1; vga_addr = 16'h3005;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    @(negedge clk);
    @(negedge clk);
    chk("cont_vga_ack", vga_ack, 1);
    chk("cont_cpu_wait", cpu_ack, 0);
    chk("cont_mem_addr_vga", mem_addr, 16'h3005);
    @(posedge clk); #1 vga_req = 0;
    @(negedge clk);
    chk("cont_cpu_ack", cpu_ack, 1);
    chk("cont_vga_ack_low", vga_ack, 0);
    chk("cont_mem_addr_cpu", mem_addr, 16'h0020);
    @(posedge clk); #1 cpu_req = 0;
    @(negedge clk);
    chk("cont_vga_valid", vga_valid, 1);
    chk("cont_cpu_valid_low", cpu_valid, 0);
    chk("cont_vga_rdata", vga_rdata, 16'h4142);
    @(negedge clk);
    chk("cont_cpu_valid", cpu_valid, 1);
    chk("cont_vga_valid_low", vga_valid, 0);
    chk("cont_cpu_rdata", cpu_rdata, 16'h1234);

    // Continuous requests from both: grants must alternate VGA, CPU, ...
    @(posedge clk); #1
    grant_log.delete();
    log_en = 1;
    vga_req = 1; vga_addr = 16'h3005;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    repeat (21) @(negedge clk);
    @(posedge clk); #1
    log_en = 0; vga_req = 0; cpu_req = 0;
    chk("alt_grant_count", grant_log.size(), 20);
    for (int i = 0; i < grant_log.size(); i++) chk("alt_grant_owner", grant_log[i], i % 2);
    repeat (4) @(negedge clk);
    chk("alt_vga_drained", vga_exp.size(), 0);
    chk("alt_cpu_drained", cpu_exp.size(), 0);

`ifdef VGA_ARB_STARVE_GUARD_EN
    // Guard: CPU acknowledged within two cycles under continuous VGA load
    begin
      int n;
      @(posedge clk); #1 vga_req = 1; vga_addr = 16'h3005;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!cpu_ack && n < 8);
      chk("guard_cpu_latency_ok", (cpu_ack && n <= 2) ? 1 : 0, 1);
      @(posedge clk); #1 vga_req = 0; cpu_req = 0;
      repeat (4) @(negedge clk);
    end
`endif

    // Reset one cycle after a VGA ack: no valid may follow
    @(posedge clk); #1 vga_req = 1; vga_addr = 16'h3005;
    wait_ack(0, "rst_vga_ack");
    @(posedge clk); #1
    reset = 1; vga_req = 0;
    vga_exp.delete();
    cpu_exp.delete();
    #1 chk_zero("rst_async");
    @(negedge clk); chk_zero("rst_held");
    @(posedge clk); #1 reset = 0;
    repeat (4) begin
      @(negedge clk); chk("rst_no_vga_valid", vga_valid, 0);
    end
    chk("final_vga_queue", vga_exp.size(), 0);
    chk("final_cpu_queue", cpu_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
